srl_fifo16: RTL and testbench

Synchronous 16-deep first-word-fall-through FIFO built on an addressable shift-register store. Writes always enter at stage 0. The read side is a reader/controller: it tracks occupancy and steers the tap address to the oldest entry, so the shift-register delay line behaves as a queue. It sits between a sample producer (decimator, demodulator) and a consumer that drains at its own rate, all in one clock domain.

---
 rtl/srl_fifo16.sv | 108 ++++++++++
 tb/tb_srl_fifo16.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/srl_fifo16.sv
// Purpose: 16-deep first-word-fall-through FIFO on an addressable shift-register store.
// Latency: a word written into an empty FIFO is on y right after its write edge; pops are visible the next cycle.
// Backpressure: full blocks writes unless a pop happens on the same edge; empty ignores pops.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous active-high reset (control state only, store is kept)
//   d/wr   - write data / write request (d enters stage 0 of the store)
//   rd     - pop request, consumes the current y
//   y      - oldest entry, 0 while empty
//   empty, full, count - occupancy status decoded from the count register
//   err    - sticky overflow/underflow flag
//
// Build option: define SRL_FIFO16_ERR_EN to enable the sticky err detector;
// without it err is tied low and no detect logic is built.

module srl_fifo16 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic         wr,
  input  logic         rd,
  output logic [W-1:0] y,
  output logic         empty,
  output logic         full,
  output logic [4:0]   count,
  output logic         err
);

  localparam logic [4:0] DEPTH = 5'd16;

  // Shift-register store. Never reset: a stale word is unreachable once count is 0.
  logic [W-1:0] sr_q [16];

  logic [4:0] count_q, count_d;
  logic [3:0] tap;
  logic       wr_ok, rd_ok;

  // Status is decoded from the count register only, so there is no
  // combinational path from wr/rd to empty/full/count/y.
  assign empty = (count_q == 5'd0);
  assign full  = (count_q == DEPTH);
  assign count = count_q;

  // A pop frees a slot on the same edge, so a write is still accepted at full
  // when rd is also high.
  assign wr_ok = wr & (~full | rd);
  assign rd_ok = rd & ~empty;

  // Oldest entry sits at count-1. Computed on the low 4 bits so count=16
  // wraps naturally to tap 15 without a 5-bit intermediate.
  assign tap = count_q[3:0] - 4'd1;

  assign y = empty ? '0 : sr_q[tap];

  // Up/down occupancy. Accept rules already keep it within 0..16, so no
  // explicit saturation is needed.
  always_comb begin
    count_d = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 5'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Store shift. On a simultaneous push and pop the oldest word moves to
  // tap+1 while count stays put, which is exactly the pop of that word.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      sr_q[0] <= d;
      for (int i = 1; i < 16; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

`ifdef SRL_FIFO16_ERR_EN
  logic err_q;
  logic ovf_evt, udf_evt;

  assign ovf_evt = wr & full & ~rd;
  assign udf_evt = rd & empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (ovf_evt || udf_evt) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_srl_fifo16.sv
module tb_srl_fifo16;

  localparam int W = 2;
`ifdef SRL_FIFO16_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d;
  logic         wr, rd;
  logic [W-1:0] y;
  logic         empty, full, err;
  logic [4:0]   count;

  srl_fifo16 #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .wr    (wr),
    .rd    (rd),
    .y     (y),
    .empty (empty),
    .full  (full),
    .count (count),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: a plain queue of words plus a sticky error bit.
  logic [W-1:0] mq[$];
  bit           merr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit w, input bit p, input logic [W-1:0] din);
    int n;
    n = mq.size();
    if (r) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      if (ERR_EN && ((w && n == 16 && !p) || (p && n == 0))) merr = 1'b1;
      if (p && n > 0) void'(mq.pop_front());
      if (w && (n < 16 || p)) mq.push_back(din);
    end
  endtask

  // One clock: drive on the falling edge, update the model right after the
  // rising edge, return 1 time unit later so literal checks see settled outputs.
  task automatic step(input bit r, input bit w, input bit p, input logic [W-1:0] din);
    @(negedge clk);
    rst = r; wr = w; rd = p; d = din;
    @(posedge clk);
    model_edge(r, w, p, din);
    #1;
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_count", {27'd0, count}, mq.size());
      chk("m_empty", {31'd0, empty}, (mq.size() == 0));
      chk("m_full",  {31'd0, full},  (mq.size() == 16));
      chk("m_y",     {30'd0, y},     (mq.size() == 0) ? 32'd0 : {30'd0, mq[0]});
      chk("m_err",   {31'd0, err},   {31'd0, merr});
    end
  end

  initial begin
    logic [W-1:0] v;
    int seq[6];
    rst = 1'b1; wr = 1'b0; rd = 1'b0; d = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    cmp_en = 1'b1;

    // Reset then idle.
    step(0, 0, 0, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full",  {31'd0, full},  0);
    chk("rst_count", {27'd0, count}, 0);
    chk("rst_y",     {30'd0, y},     0);
    chk("rst_err",   {31'd0, err},   0);

    // Write 1,2,3 then pop three times.
    seq = '{1, 2, 3, 2, 1, 0};
    for (int i = 0; i < 3; i++) begin
      v = W'(i + 1);
      step(0, 1, 0, v);
      chk("wr_count", {27'd0, count}, seq[i]);
      if (i == 0) chk("fwft_y", {30'd0, y}, 1);
    end
    for (int i = 0; i < 3; i++) begin
      chk("pop_y", {30'd0, y}, i + 1);
      step(0, 0, 1, 0);
      chk("rd_count", {27'd0, count}, seq[i+3]);
    end
    chk("drain_empty", {31'd0, empty}, 1);

    // Fill with 0,1,2,3,... then overflow attempt.
    for (int i = 0; i < 16; i++) step(0, 1, 0, W'(i % 4));
    chk("fill_full",  {31'd0, full},  1);
    chk("fill_count", {27'd0, count}, 16);
    step(0, 1, 0, 2);
    chk("ovf_count", {27'd0, count}, 16);
    chk("ovf_y",     {30'd0, y},     0);
    chk("ovf_err",   {31'd0, err},   {31'd0, ERR_EN});

    // Sustained push+pop at full: pops must continue 0,1,2,3,... seamlessly.
    for (int k = 0; k < 20; k++) begin
      chk("stream_y", {30'd0, y}, k % 4);
      step(0, 1, 1, W'((16 + k) % 4));
      chk("stream_count", {27'd0, count}, 16);
    end

    // Underflow with a simultaneous write.
    step(1, 0, 0, 0);
    step(0, 1, 1, 3);
    chk("udf_count", {27'd0, count}, 1);
    chk("udf_y",     {30'd0, y},     3);
    chk("udf_err",   {31'd0, err},   {31'd0, ERR_EN});

    // Reset beats a concurrent write at count=5.
    for (int i = 0; i < 4; i++) step(0, 1, 0, W'(i));
    chk("pre_rst_count", {27'd0, count}, 5);
    step(1, 1, 0, 1);
    chk("rstw_count", {27'd0, count}, 0);
    chk("rstw_empty", {31'd0, empty}, 1);
    chk("rstw_y",     {30'd0, y},     0);
    chk("rstw_err",   {31'd0, err},   0);

    // Random traffic with phases biased toward filling and draining.
    for (int n = 0; n < 3000; n++) begin
      int bias;
      bias = ((n / 250) % 2 == 0) ? 70 : 30;
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 99) < bias),
           ($urandom_range(0, 99) < (100 - bias)),
           W'($urandom));
    end

    step(0, 0, 0, 0);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
